// File: rtl/arp_responder.sv
// arp_responder: answers ARP requests for local_ip with a 28-byte ARP reply payload.
// Ports:
//   clk, rst_n             clock, async active-low reset
//   local_mac, local_ip    our addresses (quasi-static)
//   rx_data/valid/last     incoming ARP payload stream, no backpressure
//   tx_data/valid/ready    outgoing reply payload stream, tx_last on byte 27
//   tx_dst_mac             requester MAC for the TX framer, stable while tx_valid
//   reply_count            replies fully transmitted (saturating)
//   drop_count             accepted requests lost to full buffering (saturating)
module arp_responder #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [47:0]      local_mac,
    input  logic [31:0]      local_ip,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    input  logic             rx_last,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             tx_last,
    output logic [47:0]      tx_dst_mac,
    output logic [CNT_W-1:0] reply_count,
    output logic [CNT_W-1:0] drop_count
);

    localparam int unsigned      IDX_W    = 5;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(27);

    typedef enum logic [1:0] {P_IDLE, P_PARSE, P_DROP, P_PAD} pstate_e;
    typedef enum logic       {T_IDLE, T_SEND} tstate_e;

    // Expected request header bytes; offsets with no constraint always pass.
    function automatic logic hdr_ok(input logic [IDX_W-1:0] idx, input logic [7:0] d,
                                    input logic [31:0] ip);
        logic ok;
        ok = 1'b1;
        case (idx)
            5'd0, 5'd3, 5'd6: ok = (d == 8'h00);
            5'd1, 5'd7:       ok = (d == 8'h01);
            5'd2:             ok = (d == 8'h08);
            5'd4:             ok = (d == 8'h06);
            5'd5:             ok = (d == 8'h04);
            5'd24:            ok = (d == ip[31:24]);
            5'd25:            ok = (d == ip[23:16]);
            5'd26:            ok = (d == ip[15:8]);
            5'd27:            ok = (d == ip[7:0]);
            default:          ok = 1'b1;
        endcase
        return ok;
    endfunction

    // Byte idx of the reply payload, MSB first.
    function automatic logic [7:0] reply_byte(input logic [IDX_W-1:0] idx, input logic [47:0] mac,
                                              input logic [31:0] ip, input logic [47:0] sha,
                                              input logic [31:0] spa);
        logic [223:0] v;
        v = {64'h0001_0800_0604_0002, mac, ip, sha, spa} << {idx, 3'b000};
        return v[223:216];
    endfunction

    // Parser state
    pstate_e          p_state_q, p_state_d;
    logic [IDX_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [47:0]      sha_q, sha_d;
    logic [31:0]      spa_q, spa_d;
    logic [IDX_W-1:0] p_idx_c;
    logic             accept_c;

    // Pending buffer
    logic             pend_full_q, pend_full_d;
    logic [47:0]      pend_sha_q, pend_sha_d;
    logic [31:0]      pend_spa_q, pend_spa_d;

    // TX state
    tstate_e          t_state_q, t_state_d;
    logic [IDX_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [47:0]      tx_sha_q, tx_sha_d;
    logic [31:0]      tx_spa_q, tx_spa_d;
    logic [47:0]      tx_mac_q, tx_mac_d;
    logic [31:0]      tx_ip_q, tx_ip_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_last_q, tx_last_d;
    logic             tx_valid_q, tx_valid_d;
    logic [CNT_W-1:0] reply_cnt_q, reply_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic             tx_fire_c, tx_done_c, tx_take_c;

    // Parser next state: per-byte field check and sha/spa capture
    always_comb begin
        p_state_d = p_state_q;
        rx_cnt_d  = rx_cnt_q;
        sha_d     = sha_q;
        spa_d     = spa_q;
        accept_c  = 1'b0;
        p_idx_c   = (p_state_q == P_IDLE) ? '0 : rx_cnt_q;

        if (rx_valid) begin
            case (p_state_q)
                P_IDLE, P_PARSE: begin
                    rx_cnt_d = '0;
                    if (!hdr_ok(p_idx_c, rx_data, local_ip)) begin
                        p_state_d = rx_last ? P_IDLE : P_DROP;
                    end else begin
                        if (p_idx_c >= 5'd8 && p_idx_c <= 5'd13) begin
                            sha_d = {sha_q[39:0], rx_data};
                        end
                        if (p_idx_c >= 5'd14 && p_idx_c <= 5'd17) begin
                            spa_d = {spa_q[23:0], rx_data};
                        end
                        if (p_idx_c == LAST_IDX) begin
                            accept_c  = rx_last;
                            p_state_d = rx_last ? P_IDLE : P_PAD;
                        end else if (rx_last) begin
                            p_state_d = P_IDLE;
                        end else begin
                            p_state_d = P_PARSE;
                            rx_cnt_d  = p_idx_c + IDX_W'(1);
                        end
                    end
                end
                P_PAD: begin
                    if (rx_last) begin
                        accept_c  = 1'b1;
                        p_state_d = P_IDLE;
                    end
                end
                P_DROP: begin
                    if (rx_last) begin
                        p_state_d = P_IDLE;
                    end
                end
                default: p_state_d = P_IDLE;
            endcase
        end
    end

    // TX next state, pending buffer and counters
    always_comb begin
        tx_fire_c   = tx_valid_q && tx_ready;
        tx_done_c   = tx_fire_c && tx_last_q;
        tx_take_c   = pend_full_q && ((t_state_q == T_IDLE) || tx_done_c);

        t_state_d   = t_state_q;
        tx_cnt_d    = tx_cnt_q;
        tx_sha_d    = tx_sha_q;
        tx_spa_d    = tx_spa_q;
        tx_mac_d    = tx_mac_q;
        tx_ip_d     = tx_ip_q;
        tx_data_d   = tx_data_q;
        tx_last_d   = tx_last_q;
        tx_valid_d  = tx_valid_q;
        pend_full_d = pend_full_q;
        pend_sha_d  = pend_sha_q;
        pend_spa_d  = pend_spa_q;
        reply_cnt_d = reply_cnt_q;
        drop_cnt_d  = drop_cnt_q;

        if (tx_take_c) begin
            pend_full_d = 1'b0;
        end
        // The slot freed by a same-cycle take can be refilled immediately.
        if (accept_c) begin
            if (!pend_full_q || tx_take_c) begin
                pend_full_d = 1'b1;
                pend_sha_d  = sha_q;
                pend_spa_d  = spa_q;
            end else if (drop_cnt_q != '1) begin
                drop_cnt_d = drop_cnt_q + CNT_W'(1);
            end
        end

        if (tx_done_c && reply_cnt_q != '1) begin
            reply_cnt_d = reply_cnt_q + CNT_W'(1);
        end

        if (tx_take_c) begin
            t_state_d  = T_SEND;
            tx_cnt_d   = '0;
            tx_sha_d   = pend_sha_q;
            tx_spa_d   = pend_spa_q;
            tx_mac_d   = local_mac;
            tx_ip_d    = local_ip;
            tx_data_d  = reply_byte('0, local_mac, local_ip, pend_sha_q, pend_spa_q);
            tx_last_d  = 1'b0;
            tx_valid_d = 1'b1;
        end else if (tx_done_c) begin
            t_state_d  = T_IDLE;
            tx_cnt_d   = '0;
            tx_data_d  = 8'h00;
            tx_last_d  = 1'b0;
            tx_valid_d = 1'b0;
        end else if (tx_fire_c) begin
            tx_cnt_d   = tx_cnt_q + IDX_W'(1);
            tx_data_d  = reply_byte(tx_cnt_q + IDX_W'(1), tx_mac_q, tx_ip_q, tx_sha_q, tx_spa_q);
            tx_last_d  = ((tx_cnt_q + IDX_W'(1)) == LAST_IDX);
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_state_q   <= P_IDLE;
            rx_cnt_q    <= '0;
            sha_q       <= '0;
            spa_q       <= '0;
            pend_full_q <= 1'b0;
            pend_sha_q  <= '0;
            pend_spa_q  <= '0;
            t_state_q   <= T_IDLE;
            tx_cnt_q    <= '0;
            tx_sha_q    <= '0;
            tx_spa_q    <= '0;
            tx_mac_q    <= '0;
            tx_ip_q     <= '0;
            tx_data_q   <= '0;
            tx_last_q   <= 1'b0;
            tx_valid_q  <= 1'b0;
            reply_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            p_state_q   <= p_state_d;
            rx_cnt_q    <= rx_cnt_d;
            sha_q       <= sha_d;
            spa_q       <= spa_d;
            pend_full_q <= pend_full_d;
            pend_sha_q  <= pend_sha_d;
            pend_spa_q  <= pend_spa_d;
            t_state_q   <= t_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_sha_q    <= tx_sha_d;
            tx_spa_q    <= tx_spa_d;
            tx_mac_q    <= tx_mac_d;
            tx_ip_q     <= tx_ip_d;
            tx_data_q   <= tx_data_d;
            tx_last_q   <= tx_last_d;
            tx_valid_q  <= tx_valid_d;
            reply_cnt_q <= reply_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign tx_data     = tx_data_q;
    assign tx_valid    = tx_valid_q;
    assign tx_last     = tx_last_q;
    assign tx_dst_mac  = tx_sha_q;
    assign reply_count = reply_cnt_q;
    assign drop_count  = drop_cnt_q;

endmodule
